alu_rom_seq: RTL

ALU_ROM_SEQ -- requirements
Module: alu_rom_seq

---
 rtl/alu_rom_seq_if.sv | 45 ++++
 rtl/alu_rom_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_rom_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_rom_seq_if
// Description : Request, operand, ROM and flag-write bundle for alu_rom_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_rom_seq_if;
    logic        req;
    logic [2:0]  op_in;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        ack;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        fl;
    logic        fv;
    logic [15:0] result;
    logic [15:0] rom_y;
    logic        flout_rom;
    logic        nsetl_rom;
    logic        fvout_rom;
    logic        nsetv_rom;
    logic        nromoe;
    logic        l_wr;
    logic        l_din;
    logic        v_wr;
    logic        v_din;

    modport slave (
        input  req, op_in, a_in, b_in,
        input  rom_y, flout_rom, nsetl_rom, fvout_rom, nsetv_rom,
        input  l_wr, l_din, v_wr, v_din,
        output busy, ack, op, a, b, fl, fv, result, nromoe
    );

    modport master (
        output req, op_in, a_in, b_in,
        output rom_y, flout_rom, nsetl_rom, fvout_rom, nsetv_rom,
        output l_wr, l_din, v_wr, v_din,
        input  busy, ack, op, a, b, fl, fv, result, nromoe
    );
endinterface
`default_nettype wire

// File: rtl/alu_rom_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_rom_seq
// Description : Sequences one operation through an asynchronous ALU ROM:
//               holds operands stable, captures result/flags, drives IBus.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rom_seq #(
    parameter int SETTLE = 2,
    parameter int DRIVE  = 1
) (
    input  wire logic         clk,
    input  wire logic         nreset,
    alu_rom_seq_if.slave      bus
);
    localparam logic [3:0] c_settle_load = 4'(SETTLE - 1);
    localparam logic [3:0] c_drive_load  = 4'(DRIVE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRIVE   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_settle_cnt;
    logic [3:0]  r_drive_cnt;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_result;
    logic        r_fl;
    logic        r_fv;
    logic        w_ack;
    logic        w_nromoe;
    logic        w_ext_wr_ok;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ack        = 1'b0;
        w_nromoe     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_settle_cnt == 4'd0) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
                w_nromoe = 1'b0;
                if (r_drive_cnt == 4'd0) begin
                    w_ack        = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // External flag writes are blocked while the ROM carry-in must hold still.
    assign w_ext_wr_ok = (r_state == ST_IDLE) || (r_state == ST_DRIVE);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_settle_cnt <= 4'd0;
            r_drive_cnt  <= 4'd0;
            r_op         <= 3'd0;
            r_a          <= 16'd0;
            r_b          <= 16'd0;
            r_result     <= 16'd0;
            r_fl         <= 1'b0;
            r_fv         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_op <= bus.op_in;
                        r_a  <= bus.a_in;
                        r_b  <= bus.b_in;
                    end
                end
                ST_SETUP: begin
                    r_settle_cnt <= c_settle_load;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt != 4'd0) begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    r_result    <= bus.rom_y;
                    r_drive_cnt <= c_drive_load;
                    if (!bus.nsetl_rom) begin
                        r_fl <= bus.flout_rom;
                    end
                    if (!bus.nsetv_rom) begin
                        r_fv <= bus.fvout_rom;
                    end
                end
                ST_DRIVE: begin
                    if (r_drive_cnt != 4'd0) begin
                        r_drive_cnt <= r_drive_cnt - 4'd1;
                    end
                end
                default: begin
                    r_settle_cnt <= 4'd0;
                end
            endcase
            if (w_ext_wr_ok && bus.l_wr) begin
                r_fl <= bus.l_din;
            end
            if (w_ext_wr_ok && bus.v_wr) begin
                r_fv <= bus.v_din;
            end
        end
    end

    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.ack    = w_ack;
    assign bus.nromoe = w_nromoe;
    assign bus.op     = r_op;
    assign bus.a      = r_a;
    assign bus.b      = r_b;
    assign bus.fl     = r_fl;
    assign bus.fv     = r_fv;
    assign bus.result = r_result;
endmodule
`default_nettype wire
